// File: rtl/sprite_palette_ram_if.sv
// Pixel lookup and palette write bus for sprite_palette_ram.
// fade_level exists only when SPRITE_PALETTE_FADE_EN is defined.
interface sprite_palette_ram_if #(
  parameter int INDEX_W = 4,
  parameter int COLOR_W = 4,
  parameter int BANKS   = 2
);
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

  logic                   pix_valid;
  logic [BANK_W-1:0]      bank_sel;
  logic [INDEX_W-1:0]     index;
  logic [COLOR_W-1:0]     red;
  logic [COLOR_W-1:0]     green;
  logic [COLOR_W-1:0]     blue;
  logic                   rgb_valid;
  logic                   transparent;
  logic                   wr_en;
  logic [BANK_W-1:0]      wr_bank;
  logic [INDEX_W-1:0]     wr_addr;
  logic [3*COLOR_W-1:0]   wr_data;
  logic                   wr_ready;
  logic                   init_busy;

`ifdef SPRITE_PALETTE_FADE_EN
  logic [COLOR_W-1:0]     fade_level;

  modport master (
    output pix_valid, bank_sel, index,
    output wr_en, wr_bank, wr_addr, wr_data,
    output fade_level,
    input  red, green, blue,
    input  rgb_valid, transparent,
    input  wr_ready, init_busy
  );

  modport slave (
    input  pix_valid, bank_sel, index,
    input  wr_en, wr_bank, wr_addr, wr_data,
    input  fade_level,
    output red, green, blue,
    output rgb_valid, transparent,
    output wr_ready, init_busy
  );
`else
  modport master (
    output pix_valid, bank_sel, index,
    output wr_en, wr_bank, wr_addr, wr_data,
    input  red, green, blue,
    input  rgb_valid, transparent,
    input  wr_ready, init_busy
  );

  modport slave (
    input  pix_valid, bank_sel, index,
    input  wr_en, wr_bank, wr_addr, wr_data,
    output red, green, blue,
    output rgb_valid, transparent,
    output wr_ready, init_busy
  );
`endif
endinterface

// File: rtl/sprite_palette_ram.sv
// Multi-bank sprite palette: index -> 4:4:4 RGB, 2-cycle lookup.
// Optional fade scaling enabled by SPRITE_PALETTE_FADE_EN.
module sprite_palette_ram #(
  parameter int INDEX_W      = 4,
  parameter int COLOR_W      = 4,
  parameter int BANKS        = 2,
  parameter int TRANSP_INDEX = 2
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  sprite_palette_ram_if.slave   bus
);

  localparam int ENTRIES = 2 ** INDEX_W;
  localparam int BANK_W  = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int RGB_W   = 3 * COLOR_W;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic               valid;
    logic               zero;
    logic               transp;
`ifdef SPRITE_PALETTE_FADE_EN
    logic [COLOR_W-1:0] fade;
`endif
  } s1_t;

  typedef struct packed {
    logic               valid;
    logic               transp;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } s2_t;

`ifdef SPRITE_PALETTE_FADE_EN
  function automatic logic [COLOR_W-1:0] scale(
    input logic [COLOR_W-1:0] c,
    input logic [COLOR_W-1:0] f
  );
    logic [2*COLOR_W:0] p;
    p = (2*COLOR_W+1)'(c) *
        ((2*COLOR_W+1)'(f) + (2*COLOR_W+1)'(1));
    return COLOR_W'(p >> COLOR_W);
  endfunction
`endif

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;
  logic               init_we;
  logic               wr_ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INDEX_W'(ENTRIES - 1))
          state_d = ST_RUN;
      end
      ST_RUN: ;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    init_we  = 1'b0;
    wr_ready = 1'b0;
    unique case (state_q)
      ST_INIT: init_we  = 1'b1;
      ST_RUN:  wr_ready = 1'b1;
      default: ;
    endcase
  end

  assign bus.wr_ready  = wr_ready;
  assign bus.init_busy = init_we;

  // Grey ramp: top COLOR_W bits of {k, zeros} scale k up or down.
  logic [INDEX_W+COLOR_W-1:0] grey_wide;
  logic [COLOR_W-1:0]         grey;

  assign grey_wide = {cnt_q, {COLOR_W{1'b0}}};
  assign grey      = grey_wide[INDEX_W+COLOR_W-1 -: COLOR_W];

  logic              wr_ok;
  logic              wr_we;
  logic              rd_ok;
  logic [BANK_W-1:0] rd_bank;

  assign wr_ok   = int'(bus.wr_bank) < BANKS;
  assign wr_we   = wr_ready & bus.wr_en & wr_ok;
  assign rd_ok   = int'(bus.bank_sel) < BANKS;
  assign rd_bank = rd_ok ? bus.bank_sel : '0;

  logic [RGB_W-1:0] mem [BANKS][ENTRIES];
  logic [RGB_W-1:0] rd_data_q;

  // Read-first: the read samples the array before this edge's write.
  always_ff @(posedge Clk) begin
    if (init_we) begin
      for (int b = 0; b < BANKS; b++)
        mem[b][cnt_q] <= {grey, grey, grey};
    end else if (wr_we) begin
      mem[bus.wr_bank][bus.wr_addr] <= bus.wr_data;
    end
    rd_data_q <= mem[rd_bank][bus.index];
  end

  s1_t s1_q, s1_d;

  always_comb begin
    s1_d        = '0;
    s1_d.valid  = bus.pix_valid;
    s1_d.zero   = init_we | ~rd_ok;
    s1_d.transp = bus.pix_valid &
                  (bus.index == INDEX_W'(TRANSP_INDEX));
`ifdef SPRITE_PALETTE_FADE_EN
    s1_d.fade   = bus.fade_level;
`endif
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) s1_q <= '0;
    else          s1_q <= s1_d;
  end

  logic [COLOR_W-1:0] rd_r, rd_g, rd_b;

  assign rd_r = rd_data_q[RGB_W-1 -: COLOR_W];
  assign rd_g = rd_data_q[2*COLOR_W-1 -: COLOR_W];
  assign rd_b = rd_data_q[COLOR_W-1:0];

  s2_t s2_q, s2_d;

  always_comb begin
    s2_d        = s2_q;
    s2_d.valid  = s1_q.valid;
    s2_d.transp = s1_q.transp;
    if (s1_q.valid) begin
      if (s1_q.zero) begin
        s2_d.r = '0;
        s2_d.g = '0;
        s2_d.b = '0;
      end else begin
`ifdef SPRITE_PALETTE_FADE_EN
        s2_d.r = scale(rd_r, s1_q.fade);
        s2_d.g = scale(rd_g, s1_q.fade);
        s2_d.b = scale(rd_b, s1_q.fade);
`else
        s2_d.r = rd_r;
        s2_d.g = rd_g;
        s2_d.b = rd_b;
`endif
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) s2_q <= '0;
    else          s2_q <= s2_d;
  end

  assign bus.red         = s2_q.r;
  assign bus.green       = s2_q.g;
  assign bus.blue        = s2_q.b;
  assign bus.rgb_valid   = s2_q.valid;
  assign bus.transparent = s2_q.transp;

endmodule

// File: tb/tb_sprite_palette_ram.sv
// Testbench for sprite_palette_ram: vector table, corner sequences,
// random traffic against a palette-array reference model.
module tb_sprite_palette_ram;

  localparam int IW = 4;
  localparam int CW = 4;
  localparam int NB = 2;
  localparam int TI = 2;
  localparam int NE = 16;
  localparam int BW = 1;
  localparam int INIT_CYC = 16;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  always #5 Clk = ~Clk;

  sprite_palette_ram_if #(
    .INDEX_W(IW), .COLOR_W(CW), .BANKS(NB)
  ) bus ();

  sprite_palette_ram #(
    .INDEX_W(IW), .COLOR_W(CW),
    .BANKS(NB), .TRANSP_INDEX(TI)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  typedef struct {
    bit          valid;
    logic [11:0] rgb;
    bit          tr;
    bit          hand;
    logic [11:0] hrgb;
    bit          htr;
  } exp_t;

  typedef struct {
    bit          pv;
    int          b;
    int          idx;
    bit          we;
    int          wb;
    int          wa;
    logic [11:0] wd;
    logic [11:0] exp_rgb;
    bit          exp_t;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          edges   = 0;
  logic [11:0] pal [NB][NE];
  logic [11:0] last_rgb;
  logic [3:0]  fade_cur = 4'hF;
  exp_t        pipe [$];
  vec_t        vecs [11];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] grey_of(input int k);
    if (CW >= IW) return 4'(k << (CW - IW));
    else          return 4'(k >> (IW - CW));
  endfunction

  function automatic logic [11:0] faded(input logic [11:0] c);
    int r, g, b;
    r = (int'(c[11:8]) * (int'(fade_cur) + 1)) >> CW;
    g = (int'(c[7:4])  * (int'(fade_cur) + 1)) >> CW;
    b = (int'(c[3:0])  * (int'(fade_cur) + 1)) >> CW;
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  task automatic model_reset();
    exp_t idle;
    logic [3:0] g;
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < NE; k++) begin
        g = grey_of(k);
        pal[b][k] = {g, g, g};
      end
    idle = '{default: 0};
    pipe.delete();
    pipe.push_back(idle);
    pipe.push_back(idle);
    last_rgb = '0;
    edges = 0;
  endtask

  task automatic drive_idle();
    bus.pix_valid = 1'b0;
    bus.bank_sel  = '0;
    bus.index     = '0;
    bus.wr_en     = 1'b0;
    bus.wr_bank   = '0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
`ifdef SPRITE_PALETTE_FADE_EN
    bus.fade_level = fade_cur;
`endif
  endtask

  task automatic do_reset();
    drive_idle();
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_rgb", {bus.red, bus.green, bus.blue}, 0);
    chk("rst_valid", bus.rgb_valid, 0);
    chk("rst_transp", bus.transparent, 0);
    chk("rst_busy", bus.init_busy, 1);
    chk("rst_ready", bus.wr_ready, 0);
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic step(input bit pv, input int b, input int idx,
                      input bit we, input int wb, input int wa,
                      input logic [11:0] wd, input bit hand,
                      input logic [11:0] hrgb, input bit htr);
    exp_t e, o;
    bit   init;
    @(posedge Clk);
    #1;
    edges++;
    chk("init_busy", bus.init_busy, edges < INIT_CYC);
    chk("wr_ready", bus.wr_ready, edges >= INIT_CYC);
    if (pipe.size() >= 2) begin
      o = pipe.pop_front();
      chk("rgb_valid", bus.rgb_valid, o.valid);
      chk("transparent", bus.transparent, o.tr);
      if (o.valid) last_rgb = o.rgb;
      chk("rgb", {bus.red, bus.green, bus.blue}, last_rgb);
      if (o.hand) begin
        chk("vec_rgb", {bus.red, bus.green, bus.blue}, o.hrgb);
        chk("vec_transp", bus.transparent, o.htr);
      end
    end
    bus.pix_valid = pv;
    bus.bank_sel  = b[BW-1:0];
    bus.index     = idx[IW-1:0];
    bus.wr_en     = we;
    bus.wr_bank   = wb[BW-1:0];
    bus.wr_addr   = wa[IW-1:0];
    bus.wr_data   = wd;
`ifdef SPRITE_PALETTE_FADE_EN
    bus.fade_level = fade_cur;
`endif
    init    = edges < INIT_CYC;
    e.valid = pv;
    e.tr    = pv && (idx == TI);
    e.hand  = hand;
    e.hrgb  = hrgb;
    e.htr   = htr;
    if (!pv || init || b >= NB) e.rgb = '0;
    else                        e.rgb = faded(pal[b][idx]);
    if (we && !init && wb < NB) pal[wb][wa] = wd;
    pipe.push_back(e);
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 12'h0, 0, 12'h0, 0);
  endtask

  task automatic rand_step();
    int b, idx, wb, wa;
    bit pv, we;
    pv  = ($urandom % 4) != 0;
    b   = $urandom % NB;
    idx = $urandom % NE;
    we  = ($urandom % 3) == 0;
    wb  = $urandom % NB;
    wa  = $urandom % NE;
    if (($urandom % 4) == 0) begin
      wb = b;
      wa = idx;
    end
`ifdef SPRITE_PALETTE_FADE_EN
    fade_cur = 4'($urandom);
`endif
    step(pv, b, idx, we, wb, wa, 12'($urandom), 0, 12'h0, 0);
  endtask

  initial begin
    logic [11:0] g;
    vecs[0]  = '{1, 0, 4,  0, 0, 0,  12'h000, 12'h444, 0};
    vecs[1]  = '{1, 1, 7,  0, 0, 0,  12'h000, 12'h777, 0};
    vecs[2]  = '{0, 0, 0,  1, 0, 5,  12'hE33, 12'h000, 0};
    vecs[3]  = '{1, 0, 5,  0, 0, 0,  12'h000, 12'hE33, 0};
    vecs[4]  = '{1, 1, 5,  0, 0, 0,  12'h000, 12'h555, 0};
    vecs[5]  = '{1, 0, 3,  1, 0, 3,  12'h2B6, 12'h333, 0};
    vecs[6]  = '{1, 0, 3,  0, 0, 0,  12'h000, 12'h2B6, 0};
    vecs[7]  = '{1, 0, 2,  0, 0, 0,  12'h000, 12'h222, 1};
    vecs[8]  = '{1, 1, 2,  0, 0, 0,  12'h000, 12'h222, 1};
    vecs[9]  = '{1, 1, 15, 1, 1, 15, 12'hABC, 12'hFFF, 0};
    vecs[10] = '{1, 1, 15, 0, 0, 0,  12'h000, 12'hABC, 0};

    drive_idle();
    do_reset();

    // INIT: lookups flow with RGB forced to 0, write at cycle 3 ignored
    for (int i = 0; i < INIT_CYC - 1; i++)
      step(1, i % NB, i, i == 3, 0, 4, 12'hFFF,
           1, 12'h000, i == TI);

    foreach (vecs[i])
      step(vecs[i].pv, vecs[i].b, vecs[i].idx,
           vecs[i].we, vecs[i].wb, vecs[i].wa, vecs[i].wd,
           vecs[i].pv, vecs[i].exp_rgb, vecs[i].exp_t);

    // back-to-back stream of all indices in bank 1
    for (int k = 0; k < NE; k++) begin
      g = {4'(k), 4'(k), 4'(k)};
      step(1, 1, k, 0, 0, 0, 12'h0,
           1, (k == 15) ? 12'hABC : g, k == TI);
    end
    repeat (3) idle_step();

    repeat (1500) rand_step();

    // reset mid-stream, then random traffic through INIT and beyond
    repeat (5) step(1, 0, 9, 1, 0, 9, 12'h5A5, 0, 12'h0, 0);
    do_reset();
    repeat (40) rand_step();
    repeat (3) idle_step();

`ifdef SPRITE_PALETTE_FADE_EN
    fade_cur = 4'hF;
    step(0, 0, 0, 1, 0, 9, 12'hF0F, 0, 12'h0, 0);
    fade_cur = 4'h7;
    step(1, 0, 9, 0, 0, 0, 12'h0, 1, 12'h707, 0);
    fade_cur = 4'hF;
    step(1, 0, 9, 0, 0, 0, 12'h0, 1, 12'hF0F, 0);
    repeat (3) idle_step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
